// File: rtl/lsu_bank_xbar_arb.sv
// LSU-to-bank-group crossbar: per-bank round-robin arbitration over N_PORT requesters,
// registered bank-side outputs with valid/ready handshake, winning port index returned.
module lsu_bank_xbar_arb #(
  parameter int unsigned N_PORT = 8,
  parameter int unsigned N_BANK = 8,
  parameter int unsigned A_W    = 16,
  localparam int unsigned SEL_W = $clog2(N_BANK),
  localparam int unsigned PID_W = $clog2(N_PORT),
  localparam int unsigned REQ_W = SEL_W + A_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_PORT-1:0]         lsu_valid,
  input  logic [N_PORT*REQ_W-1:0]   lsu_addr_bus,
  output logic [N_PORT-1:0]         lsu_ready,
  output logic [N_BANK-1:0]         bg_valid,
  input  logic [N_BANK-1:0]         bg_ready,
  output logic [N_BANK*A_W-1:0]     bg_addr,
  output logic [N_BANK*PID_W-1:0]   bg_src
);

  logic [SEL_W-1:0] port_sel  [N_PORT];
  logic [A_W-1:0]   port_addr [N_PORT];

  logic [N_BANK-1:0] bg_valid_q;
  logic [A_W-1:0]    bg_addr_q [N_BANK];
  logic [PID_W-1:0]  bg_src_q  [N_BANK];
  logic [PID_W-1:0]  ptr_q     [N_BANK];

  logic [N_BANK-1:0] bank_free_c;
  logic [N_BANK-1:0] gnt_c;
  logic [PID_W-1:0]  win_c [N_BANK];

  // Split each port slice into {sel, addr}
  for (genvar gi = 0; gi < N_PORT; gi++) begin : g_port
    assign port_sel[gi]  = lsu_addr_bus[gi*REQ_W+A_W +: SEL_W];
    assign port_addr[gi] = lsu_addr_bus[gi*REQ_W +: A_W];
  end

  // Per-bank round-robin search starting at ptr, first requester wins
  always_comb begin : arb
    int unsigned      idx;
    logic [PID_W-1:0] pidx;
    logic             found;
    idx         = 0;
    pidx        = '0;
    found       = 1'b0;
    gnt_c       = '0;
    bank_free_c = '0;
    lsu_ready   = '0;
    for (int unsigned b = 0; b < N_BANK; b++) begin
      win_c[b]       = '0;
      found          = 1'b0;
      bank_free_c[b] = !bg_valid_q[b] || bg_ready[b];
      for (int unsigned k = 0; k < N_PORT; k++) begin
        idx = 32'(ptr_q[b]) + k;
        if (idx >= N_PORT) idx = idx - N_PORT;
        pidx = PID_W'(idx);
        if (!found && bank_free_c[b] && lsu_valid[pidx] && port_sel[pidx] == SEL_W'(b)) begin
          found    = 1'b1;
          win_c[b] = pidx;
        end
      end
      gnt_c[b] = found;
      if (found) lsu_ready[win_c[b]] = rst_n;
    end
  end

  // Bank holding registers and round-robin pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bg_valid_q <= '0;
      for (int unsigned b = 0; b < N_BANK; b++) begin
        bg_addr_q[b] <= '0;
        bg_src_q[b]  <= '0;
        ptr_q[b]     <= '0;
      end
    end else begin
      for (int unsigned b = 0; b < N_BANK; b++) begin
        if (gnt_c[b]) begin
          bg_valid_q[b] <= 1'b1;
          bg_addr_q[b]  <= port_addr[win_c[b]];
          bg_src_q[b]   <= win_c[b];
          ptr_q[b]      <= (win_c[b] == PID_W'(N_PORT-1)) ? '0 : win_c[b] + PID_W'(1);
        end else if (bank_free_c[b]) begin
          bg_valid_q[b] <= 1'b0;
        end
      end
    end
  end

  assign bg_valid = bg_valid_q;
  for (genvar gb = 0; gb < N_BANK; gb++) begin : g_bank
    assign bg_addr[gb*A_W +: A_W]     = bg_addr_q[gb];
    assign bg_src[gb*PID_W +: PID_W]  = bg_src_q[gb];
  end

endmodule

// File: tb/tb_lsu_bank_xbar_arb.sv
// Bench for lsu_bank_xbar_arb: directed scenarios on the 8x8 default instance and
// randomized traffic on a 4-port/16-bank instance against a behavioural model.
module tb_lsu_bank_xbar_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default instance: 8 ports, 8 banks, A_W=16 -> SEL_W=3, PID_W=3
  logic [7:0]   lsu_valid = '0;
  logic [151:0] lsu_addr_bus = '0;
  logic [7:0]   lsu_ready;
  logic [7:0]   bg_valid;
  logic [7:0]   bg_ready = '1;
  logic [127:0] bg_addr;
  logic [23:0]  bg_src;

  // Sweep instance: 4 ports, 16 banks, A_W=20 -> SEL_W=4, PID_W=2
  logic [3:0]   lsu_valid2 = '0;
  logic [95:0]  lsu_addr_bus2 = '0;
  logic [3:0]   lsu_ready2;
  logic [15:0]  bg_valid2;
  logic [15:0]  bg_ready2 = '1;
  logic [319:0] bg_addr2;
  logic [31:0]  bg_src2;

  int total = 0;
  int bad = 0;

  lsu_bank_xbar_arb dut (
    .clk(clk), .rst_n(rst_n), .lsu_valid(lsu_valid), .lsu_addr_bus(lsu_addr_bus),
    .lsu_ready(lsu_ready), .bg_valid(bg_valid), .bg_ready(bg_ready),
    .bg_addr(bg_addr), .bg_src(bg_src)
  );

  lsu_bank_xbar_arb #(.N_PORT(4), .N_BANK(16), .A_W(20)) dut2 (
    .clk(clk), .rst_n(rst_n), .lsu_valid(lsu_valid2), .lsu_addr_bus(lsu_addr_bus2),
    .lsu_ready(lsu_ready2), .bg_valid(bg_valid2), .bg_ready(bg_ready2),
    .bg_addr(bg_addr2), .bg_src(bg_src2)
  );

  task automatic set_req(input int p, input int sel, input int addr);
    lsu_addr_bus[p*19 +: 19] = {3'(sel), 16'(addr)};
    lsu_valid[p] = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    lsu_valid = '0;
    lsu_valid2 = '0;
    bg_ready = '1;
    bg_ready2 = '1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) set_req(i, i, 16'h100 + i);
    @(negedge clk);
    total++; if (bg_valid !== 8'h00) begin bad++; $display("FAIL reset_valid: got %h want 00", bg_valid); end
    total++; if (bg_addr !== '0) begin bad++; $display("FAIL reset_addr: got %h want 0", bg_addr); end
    total++; if (bg_src !== '0) begin bad++; $display("FAIL reset_src: got %h want 0", bg_src); end
    total++; if (lsu_ready !== 8'h00) begin bad++; $display("FAIL reset_ready: got %h want 00", lsu_ready); end
    lsu_valid = '0;
  endtask

  task automatic test_no_conflict();
    do_reset();
    for (int i = 0; i < 8; i++) set_req(i, i, 16'h100 + i);
    @(negedge clk);
    total++; if (lsu_ready !== 8'hFF) begin bad++; $display("FAIL noconf_ready: got %h want ff", lsu_ready); end
    step();
    lsu_valid = '0;
    @(negedge clk);
    total++; if (bg_valid !== 8'hFF) begin bad++; $display("FAIL noconf_valid: got %h want ff", bg_valid); end
    for (int b = 0; b < 8; b++) begin
      total++;
      if (bg_addr[b*16 +: 16] !== 16'(16'h100 + b) || bg_src[b*3 +: 3] !== 3'(b)) begin
        bad++;
        $display("FAIL noconf_bank%0d: got addr %h src %0d want addr %h src %0d",
                 b, bg_addr[b*16 +: 16], bg_src[b*3 +: 3], 16'h100 + b, b);
      end
    end
    step();
    @(negedge clk);
    total++; if (bg_valid !== 8'h00) begin bad++; $display("FAIL noconf_idle: got %h want 00", bg_valid); end
  endtask

  task automatic test_full_conflict();
    do_reset();
    for (int i = 0; i < 8; i++) set_req(i, 3, 16'h300 + i);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if (lsu_ready !== 8'(1 << c)) begin
        bad++; $display("FAIL conflict_ready c%0d: got %h want %h", c, lsu_ready, 8'(1 << c));
      end
      if (c > 0) begin
        total++;
        if (bg_valid[3] !== 1'b1 || bg_src[11:9] !== 3'(c - 1)) begin
          bad++; $display("FAIL conflict_src c%0d: got v%b src %0d want v1 src %0d", c, bg_valid[3], bg_src[11:9], c - 1);
        end
      end
      step();
      lsu_valid[c] = 1'b0;
    end
    @(negedge clk);
    total++; if (bg_src[11:9] !== 3'd7 || bg_addr[63:48] !== 16'h307) begin
      bad++; $display("FAIL conflict_last: got src %0d addr %h want src 7 addr 0307", bg_src[11:9], bg_addr[63:48]);
    end
    // Pointer has wrapped to 0: port 0 must beat port 5
    set_req(5, 3, 16'h355);
    set_req(0, 3, 16'h350);
    #1;
    total++; if (lsu_ready !== 8'h01) begin bad++; $display("FAIL conflict_ptr_wrap: got %h want 01", lsu_ready); end
    step();
    lsu_valid = '0;
  endtask

  task automatic test_fairness_wrap();
    do_reset();
    set_req(5, 2, 16'h55);
    @(negedge clk);
    total++; if (lsu_ready !== 8'h20) begin bad++; $display("FAIL fair_first: got %h want 20", lsu_ready); end
    step();
    lsu_valid = '0;
    set_req(1, 2, 16'h11);
    set_req(6, 2, 16'h66);
    @(negedge clk);
    total++; if (lsu_ready !== 8'h40) begin bad++; $display("FAIL fair_p6: got %h want 40", lsu_ready); end
    step();
    lsu_valid[6] = 1'b0;
    @(negedge clk);
    total++; if (lsu_ready !== 8'h02) begin bad++; $display("FAIL fair_p1: got %h want 02", lsu_ready); end
    total++; if (bg_src[8:6] !== 3'd6 || bg_addr[47:32] !== 16'h66) begin
      bad++; $display("FAIL fair_src6: got src %0d addr %h want src 6 addr 0066", bg_src[8:6], bg_addr[47:32]);
    end
    step();
    lsu_valid = '0;
    @(negedge clk);
    total++; if (bg_src[8:6] !== 3'd1) begin bad++; $display("FAIL fair_src1: got %0d want 1", bg_src[8:6]); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bg_ready[4] = 1'b0;
    set_req(2, 4, 16'h2A);
    @(negedge clk);
    total++; if (lsu_ready !== 8'h04) begin bad++; $display("FAIL bp_load: got %h want 04", lsu_ready); end
    step();
    lsu_valid = '0;
    set_req(7, 4, 16'h77);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      total++;
      if (lsu_ready[7] !== 1'b0 || bg_valid[4] !== 1'b1 || bg_src[14:12] !== 3'd2 || bg_addr[79:64] !== 16'h2A) begin
        bad++;
        $display("FAIL bp_stall s%0d: got rdy%b v%b src %0d addr %h want rdy0 v1 src 2 addr 002a",
                 s, lsu_ready[7], bg_valid[4], bg_src[14:12], bg_addr[79:64]);
      end
      step();
    end
    bg_ready[4] = 1'b1;
    #1;
    total++; if (lsu_ready !== 8'h80) begin bad++; $display("FAIL bp_release_ready: got %h want 80", lsu_ready); end
    step();
    lsu_valid = '0;
    @(negedge clk);
    total++; if (bg_valid[4] !== 1'b1 || bg_src[14:12] !== 3'd7 || bg_addr[79:64] !== 16'h77) begin
      bad++; $display("FAIL bp_after: got v%b src %0d addr %h want v1 src 7 addr 0077", bg_valid[4], bg_src[14:12], bg_addr[79:64]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 8; i++) set_req(i, 3, 16'h300 + i);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (lsu_ready !== 8'(1 << c)) begin bad++; $display("FAIL midrst_pre c%0d: got %h want %h", c, lsu_ready, 8'(1 << c)); end
      step();
      lsu_valid[c] = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bg_valid !== 8'h00 || bg_addr !== '0 || bg_src !== '0 || lsu_ready !== 8'h00) begin
      bad++; $display("FAIL midrst_async: got v %h src %h rdy %h want all 0", bg_valid, bg_src, lsu_ready);
    end
    for (int i = 0; i < 8; i++) set_req(i, 3, 16'h300 + i);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (lsu_ready !== 8'h01) begin bad++; $display("FAIL midrst_restart: got %h want 01", lsu_ready); end
    step();
    lsu_valid[0] = 1'b0;
    @(negedge clk);
    total++; if (lsu_ready !== 8'h02 || bg_src[11:9] !== 3'd0) begin
      bad++; $display("FAIL midrst_next: got rdy %h src %0d want rdy 02 src 0", lsu_ready, bg_src[11:9]);
    end
    step();
    lsu_valid = '0;
  endtask

  task automatic test_param_sweep();
    bit   m_valid [16];
    int   m_addr  [16];
    int   m_src   [16];
    int   m_ptr   [16];
    bit   pend    [4];
    int   p_sel   [4];
    int   p_addr  [4];
    int   seqn    [4];
    bit   accepted [int];
    bit   consumed [int];
    int   n_acc;
    int   n_con;
    int   found;
    int   p;
    int   a;
    int   n_pend;
    logic [3:0]  exp_rdy;
    logic [15:0] exp_valid;
    n_acc = 0;
    n_con = 0;
    for (int b = 0; b < 16; b++) begin m_valid[b] = 0; m_addr[b] = 0; m_src[b] = 0; m_ptr[b] = 0; end
    for (int i = 0; i < 4; i++) begin pend[i] = 0; p_sel[i] = 0; p_addr[i] = 0; seqn[i] = 0; end
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && cyc < 400 && $urandom_range(0, 99) < 60) begin
          pend[i]   = 1;
          p_sel[i]  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
          p_addr[i] = (i << 16) | seqn[i];
          seqn[i]++;
        end
        lsu_valid2[i] = pend[i];
        lsu_addr_bus2[i*24 +: 24] = {4'(p_sel[i]), 20'(p_addr[i])};
      end
      for (int b = 0; b < 16; b++) bg_ready2[b] = (cyc >= 400) ? 1'b1 : ($urandom_range(0, 99) < 70);
      @(negedge clk);
      for (int b = 0; b < 16; b++) exp_valid[b] = m_valid[b];
      total++; if (bg_valid2 !== exp_valid) begin bad++; $display("FAIL sweep_valid cyc%0d: got %h want %h", cyc, bg_valid2, exp_valid); end
      for (int b = 0; b < 16; b++) begin
        if (m_valid[b]) begin
          total++;
          if (bg_src2[b*2 +: 2] !== 2'(m_src[b]) || bg_addr2[b*20 +: 20] !== 20'(m_addr[b])) begin
            bad++; $display("FAIL sweep_bank%0d cyc%0d: got src %0d addr %h want src %0d addr %h",
                            b, cyc, bg_src2[b*2 +: 2], bg_addr2[b*20 +: 20], m_src[b], 20'(m_addr[b]));
          end
          if (bg_ready2[b]) begin
            a = int'(bg_addr2[b*20 +: 20]);
            total++;
            if (!accepted.exists(a) || consumed.exists(a)) begin
              bad++; $display("FAIL sweep_dup_or_unknown cyc%0d: got addr %h want one accepted, unconsumed", cyc, 20'(a));
            end else begin
              consumed[a] = 1;
              n_con++;
            end
          end
        end
      end
      // Reference: each free bank takes the first requester at or after its pointer
      exp_rdy = '0;
      for (int b = 0; b < 16; b++) begin
        if (!m_valid[b] || bg_ready2[b]) begin
          found = -1;
          for (int k = 0; k < 4; k++) begin
            p = (m_ptr[b] + k) % 4;
            if (found < 0 && pend[p] && p_sel[p] == b) found = p;
          end
          if (found >= 0) begin
            m_valid[b] = 1;
            m_addr[b]  = p_addr[found];
            m_src[b]   = found;
            m_ptr[b]   = (found + 1) % 4;
            exp_rdy[found] = 1'b1;
            accepted[p_addr[found]] = 1;
            n_acc++;
          end else begin
            m_valid[b] = 0;
          end
        end
      end
      total++; if (lsu_ready2 !== exp_rdy) begin bad++; $display("FAIL sweep_ready cyc%0d: got %h want %h", cyc, lsu_ready2, exp_rdy); end
      for (int i = 0; i < 4; i++) if (exp_rdy[i]) pend[i] = 0;
      step();
    end
    n_pend = 0;
    for (int i = 0; i < 4; i++) n_pend += int'(pend[i]);
    total++;
    if (n_acc == 0 || n_acc != n_con || n_pend != 0 || bg_valid2 !== 16'h0) begin
      bad++; $display("FAIL sweep_loss: got accepted %0d consumed %0d pending %0d valid %h want equal counts, 0 pending, idle",
                      n_acc, n_con, n_pend, bg_valid2);
    end
  endtask

  initial begin
    test_reset();
    test_no_conflict();
    test_full_conflict();
    test_fairness_wrap();
    test_backpressure();
    test_reset_mid();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
